// File: rtl/insn_fetch_if.sv
// Fetch-stage bundle: instruction memory read port, PC redirect request and the decode handshake.
// The master modport is the fetch stage. The slave modport is its environment (memory plus decode).
interface insn_fetch_if;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_insn;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_insn
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_insn
    );
endinterface

// File: rtl/insn_fetch.sv
// Instruction fetch: owns the PC, reads a 1-cycle-latency ROM and buffers words for decode.
// Define FETCH_BYPASS_EN to let a returning word skip the empty FIFO (1-cycle fetch latency).
module insn_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic          clk_i,
    input logic          rst_i,
    insn_fetch_if.master bus_if
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [31:0]     pc_q, pc_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]     pc_mem_q   [FIFO_DEPTH];
    logic [31:0]     insn_mem_q [FIFO_DEPTH];

    logic            fifo_empty;
    logic            byp_active;
    logic            pop;
    logic            pop_fifo;
    logic            byp_take;
    logic            push;
    logic            issue;
    logic [CntW-1:0] occ;

    assign fifo_empty = (count_q == '0);

`ifdef FETCH_BYPASS_EN
    assign byp_active = fifo_empty && inflight_q;
`else
    assign byp_active = 1'b0;
`endif

    assign bus_if.out_valid = !bus_if.redirect_valid && (!fifo_empty || byp_active);
    assign bus_if.out_pc    = !fifo_empty ? pc_mem_q[rd_ptr_q]
                            : (byp_active ? inflight_pc_q : 32'h0);
    assign bus_if.out_insn  = !fifo_empty ? insn_mem_q[rd_ptr_q]
                            : (byp_active ? bus_if.imem_data : 32'h0);

    assign pop      = bus_if.out_valid && bus_if.out_ready;
    assign byp_take = byp_active && pop;
    assign pop_fifo = pop && !fifo_empty;

    // Words already owed to the FIFO after this cycle's pop; issuing needs a free slot beyond them.
    assign occ   = count_q + CntW'(inflight_q) - CntW'(pop);
    assign issue = !rst_i && !bus_if.redirect_valid && (occ < CntW'(FIFO_DEPTH));

    assign bus_if.imem_en   = issue;
    assign bus_if.imem_addr = pc_q;

    assign push = inflight_q && !bus_if.redirect_valid && !byp_take;

    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (bus_if.redirect_valid) begin
            pc_d       = {bus_if.redirect_pc[31:2], 2'b00};
            inflight_d = 1'b0;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + 32'd4;
                inflight_pc_d = pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop_fifo) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop_fifo);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= 32'h0;
            inflight_q    <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Storage needs no reset: the output mux hides it while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
            insn_mem_q[wr_ptr_q] <= bus_if.imem_data;
        end
    end
endmodule
